// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO peripheral: register map,
// register data width and the sticky-flag update rule.
package gpio_pkg;

  localparam int unsigned REG_W = 32;

  localparam logic [2:0] ADDR_LED_DATA  = 3'd0;
  localparam logic [2:0] ADDR_LED_BLINK = 3'd1;
  localparam logic [2:0] ADDR_BTN_STATE = 3'd2;
  localparam logic [2:0] ADDR_BTN_EDGE  = 3'd3;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd4;

  // Write-1-to-clear sticky flags where a new set in the same cycle wins
  // over a clear of the same bit.
  function automatic logic [REG_W-1:0] w1c_next(
    input logic [REG_W-1:0] cur,
    input logic [REG_W-1:0] clr,
    input logic [REG_W-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, polarity normalisation to
// pressed=1, stable-count debounce and a one-cycle press pulse.
module btn_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 500000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic state_o,
  output logic press_o
);

  localparam int unsigned      CNT_W        = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic             RELEASED_LVL = BTN_ACTIVE_LOW;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             pressed_s;

  // Next-state: count consecutive disagreeing cycles, flip when the run is long enough
  always_comb begin
    sync1_d   = pin_i;
    sync2_d   = sync1_q;
    pressed_s = sync2_q ^ BTN_ACTIVE_LOW;
    db_d      = db_q;
    cnt_d     = {CNT_W{1'b0}};
    press_d   = 1'b0;
    if (pressed_s != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d    = pressed_s;
        cnt_d   = {CNT_W{1'b0}};
        press_d = pressed_s;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // State registers; synchroniser resets to the released pin level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RELEASED_LVL;
      sync2_q <= RELEASED_LVL;
      db_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign state_o = db_q;
  assign press_o = press_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO peripheral: debounced buttons with sticky press flags and a maskable
// level interrupt, LEDs with per-bit blink, behind a small register port.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned N_BTN          = 4,
  parameter int unsigned N_LED          = 8,
  parameter int unsigned DB_CYCLES      = 500000,
  parameter int unsigned BLINK_CYCLES   = 12500000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic               clock_50mhz,
  input  logic               reset,
  input  logic [N_BTN-1:0]   button,
  output logic [N_LED-1:0]   led_out,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [2:0]         addr,
  input  logic [REG_W-1:0]   wr_data,
  output logic [REG_W-1:0]   rd_data,
  output logic               irq
);

  localparam int unsigned   PW         = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_CYCLES - 1);

  logic [N_BTN-1:0] btn_state_s, btn_press_s;
  logic [N_LED-1:0] led_data_q, led_data_d;
  logic [N_LED-1:0] led_blink_q, led_blink_d;
  logic [N_BTN-1:0] irq_mask_q, irq_mask_d;
  logic [N_BTN-1:0] btn_edge_q, btn_edge_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             phase_q, phase_d;
  logic [N_LED-1:0] led_out_q, led_out_d;
  logic [REG_W-1:0] rd_data_q, rd_data_d;
  logic             irq_q, irq_d;
  logic [REG_W-1:0] rd_mux_s, edge_clr_s, edge_next_s;
  logic             unused_s;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES      (DB_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clk     (clock_50mhz),
      .rst     (reset),
      .pin_i   (button[g]),
      .state_o (btn_state_s[g]),
      .press_o (btn_press_s[g])
    );
  end

  // Read mux over the current register contents (pre-write values)
  always_comb begin
    rd_mux_s = {REG_W{1'b0}};
    case (addr)
      ADDR_LED_DATA:  rd_mux_s = REG_W'(led_data_q);
      ADDR_LED_BLINK: rd_mux_s = REG_W'(led_blink_q);
      ADDR_BTN_STATE: rd_mux_s = REG_W'(btn_state_s);
      ADDR_BTN_EDGE:  rd_mux_s = REG_W'(btn_edge_q);
      ADDR_IRQ_MASK:  rd_mux_s = REG_W'(irq_mask_q);
      default:        rd_mux_s = {REG_W{1'b0}};
    endcase
  end

  // Register writes, sticky edge flags, read capture and interrupt level
  always_comb begin
    led_data_d  = led_data_q;
    led_blink_d = led_blink_q;
    irq_mask_d  = irq_mask_q;
    if (wr_en) begin
      case (addr)
        ADDR_LED_DATA:  led_data_d  = wr_data[N_LED-1:0];
        ADDR_LED_BLINK: led_blink_d = wr_data[N_LED-1:0];
        ADDR_IRQ_MASK:  irq_mask_d  = wr_data[N_BTN-1:0];
        default:        led_data_d  = led_data_q;
      endcase
    end else begin
      led_data_d = led_data_q;
    end

    if (wr_en && (addr == ADDR_BTN_EDGE)) begin
      edge_clr_s = wr_data;
    end else begin
      edge_clr_s = {REG_W{1'b0}};
    end
    edge_next_s = w1c_next(REG_W'(btn_edge_q), edge_clr_s, REG_W'(btn_press_s));
    btn_edge_d  = edge_next_s[N_BTN-1:0];

    if (rd_en) begin
      rd_data_d = rd_mux_s;
    end else begin
      rd_data_d = rd_data_q;
    end

    irq_d = |(btn_edge_q & irq_mask_q);
  end

  // Blink prescaler and LED drive; uses next-cycle register values so a
  // write shows on the pins one edge after it is taken
  always_comb begin
    if (presc_q == PRESC_LAST) begin
      presc_d = {PW{1'b0}};
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + PW'(1);
      phase_d = phase_q;
    end
    led_out_d = led_data_d & (~led_blink_d | {N_LED{phase_d}});
  end

  // All peripheral state, cleared by the asynchronous reset
  always_ff @(posedge clock_50mhz or posedge reset) begin
    if (reset) begin
      led_data_q  <= {N_LED{1'b0}};
      led_blink_q <= {N_LED{1'b0}};
      irq_mask_q  <= {N_BTN{1'b0}};
      btn_edge_q  <= {N_BTN{1'b0}};
      presc_q     <= {PW{1'b0}};
      phase_q     <= 1'b0;
      led_out_q   <= {N_LED{1'b0}};
      rd_data_q   <= {REG_W{1'b0}};
      irq_q       <= 1'b0;
    end else begin
      led_data_q  <= led_data_d;
      led_blink_q <= led_blink_d;
      irq_mask_q  <= irq_mask_d;
      btn_edge_q  <= btn_edge_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      led_out_q   <= led_out_d;
      rd_data_q   <= rd_data_d;
      irq_q       <= irq_d;
    end
  end

  assign led_out  = led_out_q;
  assign rd_data  = rd_data_q;
  assign irq      = irq_q;
  assign unused_s = ^{wr_data, edge_next_s};

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised GPIO peripheral with N_BTN debounced button inputs and N_LED LED outputs with per-LED static/blink mode, controlled by a simple synchronous register port. Each button gets a sticky press-edge flag and a maskable level interrupt. The block sits between board pins and the processor/bus fabric, and replaces fixed-width LED/button ports in system tops.

## Interface

Parameters:
- N_BTN, 4: number of button channels (1..16).
- N_LED, 8: number of LED outputs (1..32).
- DB_CYCLES, 500000: consecutive stable cycles needed to accept a button change (10 ms at 50 MHz); must be ≥2.
- BLINK_CYCLES, 12500000: half-period of the blink phase, in cycles; must be ≥2.
- BTN_ACTIVE_LOW, 1: 1 means a pin level of 0 is "pressed".

Ports:
- clock_50mhz, in, 1: single clock domain.
- reset, in, 1: asynchronous, active-high reset.
- button, in, N_BTN: raw asynchronous button pins.
- led_out, out, N_LED: LED drive, active-high.
- wr_en, in, 1: register write strobe.
- rd_en, in, 1: register read strobe.
- addr, in, 3: register address.
- wr_data, in, 32: write data.
- rd_data, out, 32: read data, registered.
- irq, out, 1: level interrupt, registered.

## Operation

Registers (unused bits read 0, writes to them are ignored):
- 0 LED_DATA (RW): the LED on/off pattern.
- 1 LED_BLINK (RW): when bit i is 1, LED i blinks.
- 2 BTN_STATE (RO): the debounced pressed state.
- 3 BTN_EDGE (RW1C): sticky flags, set on a debounced press.
- 4 IRQ_MASK (RW): per-button interrupt enable.
- 5–7: read 0, writes are ignored.

Button path:
- Each channel has a 2-flop synchroniser, followed by polarity normalisation to pressed=1.
- Debounce counter: increments while the synchronised value differs from the debounced value, and clears to 0 whenever they agree.
- When the counter reaches DB_CYCLES-1 and the values still differ, the debounced value flips and the counter clears.
- A glitch shorter than DB_CYCLES cycles never changes the debounced value.
- A debounced 0→1 transition sets the BTN_EDGE bit on the next cycle. A release sets no flag.

Edge and interrupt rules:
- Writing 1 to a BTN_EDGE bit clears it; writing 0 leaves it unchanged.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq is registered from |(BTN_EDGE & IRQ_MASK).

LED path:
- A shared prescaler counts 0..BLINK_CYCLES-1 and wraps to 0. The blink phase toggles on each wrap.
- led_out[i] = LED_DATA[i] & (LED_BLINK[i] ? phase : 1), registered.

Bus:
- If wr_en and rd_en are asserted together, the write is performed and the read returns the pre-write value.

Reset values (asynchronous):
- All registers 0.
- Synchroniser flops at the released level (1 if BTN_ACTIVE_LOW).
- Debounced state released; debounce counters 0; prescaler 0; phase 0.
- led_out 0, rd_data 0, irq 0.

Reset asserted mid-operation aborts any pending debounce count and loses all flags.

## Timing

- Pin change to BTN_STATE update: 2 sync cycles + DB_CYCLES cycles.
- BTN_EDGE is set 1 cycle after BTN_STATE changes; irq follows 1 cycle after that.
- Write to LED_DATA/LED_BLINK at edge k: led_out reflects it at edge k+1.
- Read: rd_en at edge k gives rd_data valid after edge k+1. rd_data holds its value when rd_en is low.
- Blink phase toggles every BLINK_CYCLES cycles; the first toggle occurs BLINK_CYCLES cycles after reset release.
- A button held through reset release is reported as pressed 2+DB_CYCLES cycles later, and its edge flag is set.
- W1C of a flag at edge k: BTN_EDGE reads 0 from edge k+1, and irq deasserts at edge k+2 if no other unmasked flag is set.

## Structure

- Package gpio_pkg holds the register address constants (ADDR_LED_DATA … ADDR_IRQ_MASK) and the register data width (32).
- Sub-module btn_debounce handles one channel: synchroniser, polarity, counter, debounced output and press pulse. It is parametrised by DB_CYCLES and BTN_ACTIVE_LOW, and instantiated N_BTN times by a generate loop.
- Register file, edge flags, prescaler and LED mux live in gpio_ctrl.

## Test plan

Bench parameters: N_BTN=4, N_LED=8, DB_CYCLES=4, BLINK_CYCLES=8, BTN_ACTIVE_LOW=1.

- **Reset:** assert reset mid-run → led_out=0x00, irq=0, rd_data=0; a read of addr 2 after release returns 0.
- **Debounce:** drive button[1]=0 for 3 cycles, then 1 → BTN_STATE stays 0x0 and no edge. Then hold button[1]=0 → BTN_STATE=0x2 exactly 6 cycles after the pin change.
- **Edge/irq:** IRQ_MASK=0x2, press button[1] → BTN_EDGE=0x2 and irq=1 two cycles after BTN_STATE. Write 0x2 to addr 3 → irq=0 two cycles later. Releasing the button sets no flag.
- **Set/clear collision:** issue a W1C of bit 1 in the exact cycle a new press sets bit 1 → BTN_EDGE bit 1 reads 1.
- **Blink:** LED_DATA=0xFF, LED_BLINK=0x0F → led_out alternates 0xF0 / 0xFF every 8 cycles, starting at 0xF0 after reset.
- **Unused address:** write 0xFFFFFFFF to addr 6, then read it → 0; other registers are unchanged.
